hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / RAW stall detection, flush control and EX operand forwarding
// for a five-stage pipeline.
//
// An internal scoreboard mirrors the EX, MEM and WB pipeline registers. It holds only
// what hazard decisions need: write enable and destination everywhere, plus the load
// flag and source registers for the EX entry.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      ID stage holds a real instruction
//   id_rs, id_rt                  ID source register numbers
//   id_uses_rs, id_uses_rt        ID instruction reads rs / rt
//   id_write_reg, id_mem_to_reg   ID instruction writes a register / is a load
//   id_reg_dst                    ID destination register (RegDst already applied)
//   mem_redirect                  taken branch or jump resolved in MEM this cycle
//   pc_en, if_id_en               PC and IF/ID load enables
//   id_ex_bubble                  ID/EX loads a NOP
//   flush_if_id/_id_ex/_ex_mem    clear the named pipeline register
//   fwd_a_sel, fwd_b_sel          EX operand source: 00 regfile, 01 MEM, 10 WB
//   stall_cnt                     saturating count of stall cycles
//
// Build option: define HAZARD_FWD_EN to enable forwarding. Only loads in EX then stall.
// Without it, the forwarding selects are tied to 00. Any producer still in EX or MEM
// stalls ID. WB never stalls because the register file writes on the falling edge.
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_write_reg,
  input  logic        id_mem_to_reg,
  input  logic [4:0]  id_reg_dst,
  input  logic        mem_redirect,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_bubble,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       we;
    logic [4:0] dst;
    logic       load;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_entry_t;

  // Past EX only the destination matters, so the load flag and sources are dropped.
  typedef struct packed {
    logic       we;
    logic [4:0] dst;
  } dst_entry_t;

  ex_entry_t  ex_q, ex_d;
  dst_entry_t mem_q, mem_d;
  dst_entry_t wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic raw;
  logic stall;

  // Register 0 and non-writing entries never match.
  function automatic logic src_hit(input logic we, input logic [4:0] dst,
                                   input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  logic rs_hit_ex, rt_hit_ex;
  assign rs_hit_ex = id_uses_rs && src_hit(ex_q.we, ex_q.dst, id_rs);
  assign rt_hit_ex = id_uses_rt && src_hit(ex_q.we, ex_q.dst, id_rt);

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign raw = ex_q.load && (rs_hit_ex || rt_hit_ex);

  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (src_hit(mem_q.we, mem_q.dst, ex_q.rs)) begin
      fwd_a_sel = 2'b01;
    end else if (src_hit(wb_q.we, wb_q.dst, ex_q.rs)) begin
      fwd_a_sel = 2'b10;
    end
    if (src_hit(mem_q.we, mem_q.dst, ex_q.rt)) begin
      fwd_b_sel = 2'b01;
    end else if (src_hit(wb_q.we, wb_q.dst, ex_q.rt)) begin
      fwd_b_sel = 2'b10;
    end
  end
`else
  logic rs_hit_mem, rt_hit_mem;
  assign rs_hit_mem = id_uses_rs && src_hit(mem_q.we, mem_q.dst, id_rs);
  assign rt_hit_mem = id_uses_rt && src_hit(mem_q.we, mem_q.dst, id_rt);
  assign raw        = rs_hit_ex || rt_hit_ex || rs_hit_mem || rt_hit_mem;

  assign fwd_a_sel  = 2'b00;
  assign fwd_b_sel  = 2'b00;

  // Without forwarding these fields are tracked but never consulted.
  logic unused_nofwd;
  assign unused_nofwd = ^{ex_q.load, ex_q.rs, ex_q.rt, wb_q};
`endif

  // A redirect squashes the ID instruction anyway, so it must not stall.
  assign stall        = id_valid && !mem_redirect && raw;

  assign pc_en        = !stall;
  assign if_id_en     = !stall;
  assign id_ex_bubble = stall;
  assign flush_if_id  = mem_redirect;
  assign flush_id_ex  = mem_redirect;
  assign flush_ex_mem = mem_redirect;
  assign stall_cnt    = stall_cnt_q;

  always_comb begin
    wb_d        = mem_q;
    mem_d       = '{we: ex_q.we, dst: ex_q.dst};
    ex_d        = '0;
    stall_cnt_d = stall_cnt_q;

    if (mem_redirect) begin
      mem_d = '0;
    end else if (!stall && id_valid) begin
      ex_d = '{we: id_write_reg, dst: id_reg_dst, load: id_mem_to_reg,
               rs: id_rs, rt: id_rt};
    end

    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
